// File: rtl/axis_bram_master.sv
// Streams one FFT frame from a result BRAM onto an AXI4-Stream master port.
// A 2-entry buffer hides the 1-cycle BRAM read latency and absorbs backpressure.
module axis_bram_master #(
    parameter int DATA_WIDTH = 64,
    parameter int FFT_SIZE   = 4096,
    parameter int ADDR_WIDTH = $clog2(FFT_SIZE),
    parameter int BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  axis_bram_master_go,
    output logic                  axis_bram_master_busy,
    output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
    output logic                  axis_mem2m_re,
    input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [BYTE_COUNT-1:0] m_axis_tkeep
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   FRAME_END = (ADDR_WIDTH + 1)'(FFT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(FFT_SIZE - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH:0]     raddr_q;
    logic [ADDR_WIDTH-1:0]   beat_q;
    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              fifo_count_q;
    logic                    pop_s;
    logic                    re_s;
    logic [2:0]              occupancy_s;

    assign pop_s                 = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid         = (fifo_count_q != 2'd0);
    assign m_axis_tdata          = fifo_mem_q[rd_ptr_q];
    assign m_axis_tlast          = m_axis_tvalid && (beat_q == LAST_BEAT);
    assign m_axis_tkeep          = {BYTE_COUNT{1'b1}};
    assign axis_bram_master_busy = (state_q != IDLE);
    assign axis_mem2m_raddr      = raddr_q[ADDR_WIDTH-1:0];
    assign axis_mem2m_re         = re_s;

    // Read credit: words buffered plus the one in flight, net of this cycle's pop, must stay below 2.
    always_comb begin
        occupancy_s = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        re_s        = (state_q == READ) && (raddr_q < FRAME_END) && (occupancy_s < 3'd2);
    end

    // Next-state logic: leave READ only when the final beat is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (axis_bram_master_go) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (pop_s && m_axis_tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/beat counters, read-latency tracker and the 2-entry output buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr_q       <= {(ADDR_WIDTH + 1){1'b0}};
            beat_q        <= {ADDR_WIDTH{1'b0}};
            inflight_q    <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_count_q  <= 2'd0;
            fifo_mem_q[0] <= {DATA_WIDTH{1'b0}};
            fifo_mem_q[1] <= {DATA_WIDTH{1'b0}};
        end else if (state_q == IDLE) begin
            raddr_q      <= {(ADDR_WIDTH + 1){1'b0}};
            beat_q       <= {ADDR_WIDTH{1'b0}};
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
        end else begin
            inflight_q <= re_s;
            if (re_s) begin
                raddr_q <= raddr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                beat_q   <= beat_q + {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (inflight_q) begin
                fifo_mem_q[wr_ptr_q] <= axis_mem2m_rdata;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            case ({inflight_q, pop_s})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_master.sv
// Randomized self-checking bench for axis_bram_master: BRAM model holds mem[i]=i and
// a transaction-level model tracks reads issued versus beats accepted.
module tb_axis_bram_master;

    localparam int DW  = 64;
    localparam int FFT = 16;
    localparam int AW  = 4;
    localparam int BC  = DW / 8;

    logic          clk;
    logic          reset;
    logic          go;
    logic          busy;
    logic [AW-1:0] raddr;
    logic          re;
    logic [DW-1:0] rdata;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic [BC-1:0] tkeep;
    logic [DW-1:0] mem [FFT];

    int n_cmp;
    int n_err;
    int cyc;
    int accepted;
    int reads;
    int tlast_cnt;
    int first_valid;
    int last_pop;
    int go_cyc;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;

    axis_bram_master #(.DATA_WIDTH(DW), .FFT_SIZE(FFT)) dut (
        .clk(clk), .reset(reset), .axis_bram_master_go(go),
        .axis_bram_master_busy(busy), .axis_mem2m_raddr(raddr),
        .axis_mem2m_re(re), .axis_mem2m_rdata(rdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .m_axis_tkeep(tkeep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_frame();
        accepted    = 0;
        reads       = 0;
        tlast_cnt   = 0;
        first_valid = -1;
        last_pop    = -1;
        prev_stall  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample settled outputs, advance the model.
    task automatic cycle(input bit rdy, input bit g);
        bit pop;
        @(negedge clk);
        tready = rdy;
        go     = g;
        #1;
        cyc++;
        pop = tvalid && tready;
        if (prev_stall) begin
            chk("stall_valid", 64'(tvalid), 64'd1);
            chk("stall_data", tdata, prev_data);
            chk("stall_last", 64'(tlast), 64'(prev_last));
        end
        if (re) begin
            chk("re_occupancy", 64'((reads - accepted - int'(pop)) < 2), 64'd1);
            chk("re_addr", 64'(raddr), 64'(reads));
            chk("re_limit", 64'(reads < FFT), 64'd1);
            reads++;
        end
        if (tvalid && first_valid < 0) first_valid = cyc;
        if (tvalid) begin
            chk("tlast", 64'(tlast), 64'(accepted == FFT - 1));
            chk("tkeep", 64'(tkeep), 64'(8'hFF));
        end
        if (pop) begin
            chk("tdata", tdata, mem[accepted % FFT]);
            if (tlast) tlast_cnt++;
            accepted++;
            last_pop = cyc;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
    endtask

    // Run cycles after the go edge until the frame completes or the budget expires.
    task automatic run_until_done(input int pct, input int gmode, input int budget);
        bit g;
        for (int i = 0; i < budget && accepted < FFT; i++) begin
            g = (gmode == 2) ? 1'b1 : (gmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycle($urandom_range(0, 99) < pct, g);
            chk("busy_in_frame", 64'(busy), 64'd1);
        end
        chk("frame_len", 64'(accepted), 64'(FFT));
        chk("tlast_count", 64'(tlast_cnt), 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < FFT; i++) mem[i] = 64'(i);
        new_frame();
        reset  = 1'b1;
        go     = 1'b0;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_re", 64'(re), 64'd0);
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_tkeep", 64'(tkeep), 64'(8'hFF));
        reset = 1'b0;

        // Full-rate frame: latency, throughput and busy drop.
        new_frame();
        cycle(1'b1, 1'b1);
        go_cyc = cyc;
        chk("go_idle_busy", 64'(busy), 64'd0);
        run_until_done(100, 0, 60);
        chk("first_valid_lat", 64'(first_valid - go_cyc), 64'd3);
        chk("last_accept_lat", 64'(last_pop - go_cyc), 64'(FFT + 2));
        cycle(1'b1, 1'b0);
        chk("busy_after", 64'(busy), 64'd0);

        // Random 50% backpressure.
        new_frame();
        cycle(1'b0, 1'b1);
        run_until_done(50, 0, 400);
        cycle(1'b0, 1'b0);

        // Long stall right after go: exactly two reads, head word held.
        new_frame();
        cycle(1'b0, 1'b1);
        repeat (20) cycle(1'b0, 1'b0);
        chk("hold_tvalid", 64'(tvalid), 64'd1);
        chk("hold_tdata", tdata, 64'd0);
        chk("hold_reads", 64'(reads), 64'd2);
        chk("hold_re", 64'(re), 64'd0);
        run_until_done(100, 0, 60);
        cycle(1'b1, 1'b0);

        // go toggling mid-frame and during stalls is ignored.
        new_frame();
        cycle(1'b1, 1'b1);
        run_until_done(50, 1, 400);
        cycle(1'b1, 1'b0);

        // go held high across tlast launches a second frame from IDLE.
        new_frame();
        cycle(1'b1, 1'b1);
        run_until_done(100, 2, 60);
        new_frame();
        cycle(1'b1, 1'b1);
        go_cyc = cyc;
        chk("rego_idle_busy", 64'(busy), 64'd0);
        run_until_done(100, 0, 60);
        chk("rego_first_lat", 64'(first_valid - go_cyc), 64'd3);
        cycle(1'b1, 1'b0);

        // Reset mid-frame, then a clean frame.
        new_frame();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 40 && accepted < 7; i++) cycle(1'b1, 1'b0);
        chk("pre_reset_beats", 64'(accepted), 64'd7);
        reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_re", 64'(re), 64'd0);
        chk("mid_rst_tlast", 64'(tlast), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        new_frame();
        cycle(1'b1, 1'b1);
        run_until_done(70, 0, 200);
        cycle(1'b1, 1'b0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
